// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding RV32I byte/half/word load or store over
// valid/ready handshakes, with WAIT_CYCLES wait states before the response.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [2:0]        a_funct3;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [2:0]        op_funct3;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              in_range;
  logic              err_c;
  logic              commit_c;
  logic [DATA_W-1:0] word_c;
  logic [DATA_W-1:0] rdata_c;
  logic [DATA_W-1:0] wdata_c;
  logic [3:0]        be_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;

  assign req_ready = (state == S_IDLE) && !reset;
  assign busy      = (state != S_IDLE);

  // Decode the live request in IDLE (zero-wait commit) and the latched copy otherwise
  always_comb begin
    op_we     = (state == S_IDLE) ? req_we     : a_we;
    op_addr   = (state == S_IDLE) ? req_addr   : a_addr;
    op_wdata  = (state == S_IDLE) ? req_wdata  : a_wdata;
    op_funct3 = (state == S_IDLE) ? req_funct3 : a_funct3;
    idx       = op_addr[ADDR_W-1:2];
    lane      = op_addr[1:0];
    in_range  = 32'(idx) < DEPTH_WORDS;
    word_c    = in_range ? mem[MEM_AW'(idx)] : '0;
    byte_c    = word_c[{lane, 3'b000} +: 8];
    half_c    = lane[1] ? word_c[31:16] : word_c[15:0];
    err_c     = !in_range;
    rdata_c   = '0;
    be_c      = '0;
    wdata_c   = op_wdata;
    case (op_funct3)
      3'b000: begin
        rdata_c = {{24{byte_c[7]}}, byte_c};
        be_c    = 4'b0001 << lane;
        wdata_c = {4{op_wdata[7:0]}};
      end
      3'b001: begin
        err_c   = err_c | lane[0];
        rdata_c = {{16{half_c[15]}}, half_c};
        be_c    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{op_wdata[15:0]}};
      end
      3'b010: begin
        err_c   = err_c | (lane != 2'd0);
        rdata_c = word_c;
        be_c    = 4'b1111;
      end
      3'b100: begin
        err_c   = err_c | op_we;
        rdata_c = {24'd0, byte_c};
      end
      3'b101: begin
        err_c   = err_c | op_we | lane[0];
        rdata_c = {16'd0, half_c};
      end
      default: err_c = 1'b1;
    endcase
    if (err_c || op_we) rdata_c = '0;
    if (err_c || !op_we) be_c = '0;
    commit_c = ((state == S_IDLE) && req_valid && req_ready && (WAIT_CYCLES == 0)) ||
               ((state == S_WAIT) && (wait_cnt == CNT_W'(1)));
  end

  // Storage array, written only on the edge that enters RESP; not reset
  always_ff @(posedge clk) begin
    if (commit_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[MEM_AW'(idx)][8*i +: 8] <= wdata_c[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      a_we      <= 1'b0;
      a_addr    <= '0;
      a_wdata   <= '0;
      a_funct3  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a_we     <= req_we;
            a_addr   <= req_addr;
            a_wdata  <= req_wdata;
            a_funct3 <= req_funct3;
            if (WAIT_CYCLES == 0) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rdata_c;
              rsp_err   <= err_c;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= CNT_W'(WAIT_CYCLES);
            end
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - CNT_W'(1);
          if (wait_cnt == CNT_W'(1)) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_c;
            rsp_err   <= err_c;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed RV32I cases plus random traffic checked against
// a byte-addressed memory model; a second zero-wait instance checks minimum latency.
module tb_dmem_responder;
  localparam int unsigned WAIT  = 2;
  localparam int unsigned DEPTH = 128;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [8:0]  z_req_addr;
  logic [31:0] z_req_wdata;
  logic [2:0]  z_req_funct3;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err, z_busy;
  logic [31:0] z_rsp_rdata;

  int checks = 0;
  int errors = 0;
  logic [7:0] mm [512];

  dmem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_funct3(z_req_funct3),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .busy(z_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference rules: legality, access size, little-endian byte reads with extension
  function automatic logic m_err(input logic we, input logic [8:0] a, input logic [2:0] f3);
    if ((int'(a) >> 2) >= int'(DEPTH)) return 1'b1;
    case (f3)
      3'd0:    return 1'b0;
      3'd1:    return a[0];
      3'd2:    return a[1:0] != 2'd0;
      3'd4:    return we;
      3'd5:    return we || a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [8:0] a, input logic [2:0] f3);
    logic [31:0] v;
    int n;
    v = 32'd0;
    n = m_size(f3);
    for (int b = 0; b < n; b++) v = v | (32'(mm[int'(a) + b]) << (8 * b));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic txn(input logic we, input logic [8:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, input int hold,
                     output logic o_err, output logic [31:0] o_rdata);
    int n;
    int lat;
    logic e_err;
    logic [31:0] e_rd;
    e_err = m_err(we, a, f3);
    e_rd  = (e_err || we) ? 32'd0 : m_load(a, f3);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
    rsp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 9'($urandom);
    req_wdata = $urandom; req_funct3 = 3'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("latency", 32'(lat), 32'(WAIT + 1));
    o_err = rsp_err;
    o_rdata = rsp_rdata;
    chk("rsp_err", 32'(o_err), 32'(e_err));
    chk("rsp_rdata", o_rdata, e_rd);
    if (!e_err && we)
      for (int b = 0; b < m_size(f3); b++) mm[int'(a) + b] = wd[8*b +: 8];
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h040; req_wdata = $urandom; req_funct3 = 3'd2;
      @(posedge clk); #1;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, e_rd);
      chk("hold_rsp_err", 32'(rsp_err), 32'(e_err));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic        e;
    logic [31:0] r;
    logic        rw;
    logic [8:0]  ra;
    logic [2:0]  rf;
    int          n;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_funct3 = '0; rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0;
    z_req_funct3 = '0; z_rsp_ready = 1'b1;
    #2;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post_reset_req_ready", 32'(req_ready), 32'd1);

    // Fill every word so later random loads have known contents
    for (int i = 0; i < int'(DEPTH); i++) txn(1'b1, 9'(i * 4), $urandom, 3'd2, 0, e, r);

    txn(1'b1, 9'h010, 32'hDEADBEEF, 3'd2, 0, e, r);
    chk("sw_rdata_zero", r, 32'd0);
    txn(1'b0, 9'h010, 32'd0, 3'd2, 0, e, r);
    chk("lw_deadbeef", r, 32'hDEADBEEF);
    chk("lw_deadbeef_err", 32'(e), 32'd0);
    txn(1'b1, 9'h011, 32'h000000A5, 3'd0, 0, e, r);
    txn(1'b0, 9'h010, 32'd0, 3'd2, 0, e, r);
    chk("lw_after_sb", r, 32'hDEADA5EF);
    txn(1'b0, 9'h011, 32'd0, 3'd0, 0, e, r);
    chk("lb_sext", r, 32'hFFFFFFA5);
    txn(1'b0, 9'h011, 32'd0, 3'd4, 0, e, r);
    chk("lbu_zext", r, 32'h000000A5);
    txn(1'b1, 9'h012, 32'h00008001, 3'd1, 0, e, r);
    txn(1'b0, 9'h012, 32'd0, 3'd1, 0, e, r);
    chk("lh_sext", r, 32'hFFFF8001);
    txn(1'b0, 9'h012, 32'd0, 3'd5, 0, e, r);
    chk("lhu_zext", r, 32'h00008001);
    txn(1'b0, 9'h010, 32'd0, 3'd2, 0, e, r);
    chk("lw_after_sh", r, 32'h8001A5EF);

    txn(1'b0, 9'h013, 32'd0, 3'd2, 0, e, r);
    chk("err_lw_misaligned", {31'd0, e}, 32'd1);
    chk("err_lw_misaligned_rdata", r, 32'd0);
    txn(1'b1, 9'h011, 32'hFFFFFFFF, 3'd1, 0, e, r);
    chk("err_sh_misaligned", {31'd0, e}, 32'd1);
    txn(1'b0, 9'h010, 32'd0, 3'd3, 0, e, r);
    chk("err_funct3_011", {31'd0, e}, 32'd1);
    chk("err_funct3_011_rdata", r, 32'd0);
    txn(1'b1, 9'h010, 32'hFFFFFFFF, 3'd4, 0, e, r);
    chk("err_sb_funct3_100", {31'd0, e}, 32'd1);
    txn(1'b0, 9'h010, 32'd0, 3'd2, 0, e, r);
    chk("lw_after_errors", r, 32'h8001A5EF);

    // Backpressure with ignored concurrent requests (stores to 0x040)
    txn(1'b0, 9'h010, 32'd0, 3'd2, 5, e, r);
    chk("lw_held", r, 32'h8001A5EF);
    txn(1'b0, 9'h040, 32'd0, 3'd2, 0, e, r);

    // Zero-wait instance: response visible right after the accept edge
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 9'h010; z_req_wdata = 32'hDEADBEEF;
    z_req_funct3 = 3'd2;
    @(posedge clk); #1;
    z_req_valid = 1'b0; z_req_wdata = 32'h0; z_req_we = 1'b0;
    chk("z_sw_latency1", 32'(z_rsp_valid), 32'd1);
    chk("z_sw_err", 32'(z_rsp_err), 32'd0);
    @(posedge clk); #1;
    chk("z_idle", 32'(z_busy), 32'd0);
    z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 9'h010; z_req_funct3 = 3'd2;
    @(posedge clk); #1;
    z_req_valid = 1'b0; z_req_addr = 9'h000;
    chk("z_lw_latency1", 32'(z_rsp_valid), 32'd1);
    chk("z_lw_rdata", z_rsp_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      rw = 1'($urandom);
      rf = 3'($urandom);
      ra = 9'($urandom);
      if ($urandom_range(0, 3) != 0) ra = ra & ~9'(m_size(rf) - 1);
      txn(rw, ra, $urandom, rf, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, e, r);
    end

    // Reset during WAIT aborts an uncommitted store
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h020; req_wdata = 32'h12345678;
    req_funct3 = 3'd2; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_busy_wait", 32'(busy), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_release_req_ready", 32'(req_ready), 32'd1);
    txn(1'b0, 9'h020, 32'd0, 3'd2, 0, e, r);

    // Reset while a response is pending drops it immediately
    req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h020; req_funct3 = 3'd2; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("resp_pending_valid", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("resp_drop_valid", 32'(rsp_valid), 32'd0);
    chk("resp_drop_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    rsp_ready = 1'b1;
    #1;
    txn(1'b0, 9'h020, 32'd0, 3'd2, 0, e, r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
